mem_copy_monitor: RTL and testbench
===================================

Name: mem_copy_monitor

Overview:
- Multi-channel, parametrised successor to the single-channel memory-copy completion detector.
- Each channel watches its memory-output lane for a configurable alternating marker sequence: all-ones, all-zeros, all-ones, … with NO_OF_MARKERS entries.
- Reports per-channel sticky done, a one-cycle done pulse, a watchdog timeout flag, and a global saturating count of completed transfers.
- Sits between the memory-copy engine and the online-arithmetic control sequencer.

Parameters:
- no_of_mem_bits, 2: width of one channel's data lane.
- no_of_channels, 4: number of independent lanes monitored.
- no_of_markers, 4: length of the marker sequence; legal range 2..16; entry k is all-ones for even k, all-zeros for odd k.
- timeout_cycles, 1024: watchdog limit in cycles; 0 disables the watchdog.
- count_width, 8: width of the completed-transfer counter.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- enable, input, no_of_channels: per-channel re-arm/hold; while high, that channel is held at marker index 0.
- data_in, input, no_of_channels*no_of_mem_bits: channel c occupies bits [c*no_of_mem_bits +: no_of_mem_bits].
- transfer_done, output, no_of_channels: sticky done per channel.
- done_pulse, output, no_of_channels: one-cycle pulse on the cycle transfer_done rises.
- timeout, output, no_of_channels: sticky watchdog-expired flag.
- all_done, output, 1: AND of transfer_done.
- transfer_count, output, count_width: saturating count of done pulses since rst.

Behaviour:
- All outputs are registered.
- **Reset:** rst forces, on the next edge, every channel to SEEK with idx=0 and wdog=0. It clears transfer_done, done_pulse, timeout, all_done and transfer_count to 0. rst takes priority over everything, including mid-sequence and in DONE.
- **Per-channel FSM states:** SEEK, DONE, TOUT. Per-channel state: idx (marker index, clog2(no_of_markers) bits) and wdog (watchdog counter).
- **enable[c] high (rst low):** channel c goes to SEEK with idx=0 and wdog=0. Its transfer_done, done_pulse and timeout are cleared. transfer_count is untouched.
- **SEEK, enable low:**
  - expected = all-ones if idx is even, all-zeros if idx is odd.
  - If lane == expected and idx < no_of_markers-1: idx increments.
  - If lane == expected and idx == no_of_markers-1: go to DONE. transfer_done[c] and done_pulse[c] are 1 on the following cycle.
  - Any other lane value (mismatch, or mixed bits): hold idx; there is no backtracking.
  - wdog increments each SEEK cycle while timeout_cycles != 0.
  - When wdog == timeout_cycles-1 and no completion occurs that cycle: go to TOUT with timeout[c]=1.
  - If the final marker and watchdog expiry coincide, completion wins.
- **DONE:** hold transfer_done=1, done_pulse=0, ignore data_in. Leave only via enable or rst.
- **TOUT:** hold timeout=1, transfer_done=0. Leave only via enable or rst.
- **Latency:** final marker sampled at edge N → transfer_done and done_pulse high after edge N; all_done updates at the same edge.
- **transfer_count:** adds popcount(done_pulse next-state) each cycle, so simultaneous completions on several channels all count. It saturates at 2^count_width-1 and never wraps.
- **Marker sequence without bounce:** consecutive identical samples do not advance the index, because the expected value alternates. E.g. ones,ones,zeros advances idx 0→1→1→2.
- **no_of_mem_bits=1:** a lane of 1 is all-ones and a lane of 0 is all-zeros; no special case is needed.
- **Defaults equivalence:** with no_of_markers=4 and the watchdog disabled, a channel matches the legacy 4-step detection order, but done is sticky instead of data-gated.

Decomposition:
- Package mem_copy_monitor_pkg holds:
  - state enum {SEEK, DONE, TOUT}.
  - function expected_marker(idx, width).
  - localparam IDX_W = clog2(no_of_markers).
  - localparam WDOG_W = clog2(timeout_cycles+1).
- Sub-module mem_copy_channel_fsm holds one lane's FSM, idx, wdog and its three flag registers.
- The top level instantiates no_of_channels copies and adds all_done, popcount and the saturating counter.

Test Plan:
- **Basic completion:** rst, then enable=0, ch0 lane sequence 3,1,0,2,3,3,0 (no_of_mem_bits=2) → idx 1,1,2,2,3,3, then transfer_done[0]=1 after the 7th edge. done_pulse[0] is high for exactly 1 cycle and transfer_count=1.
- **Simultaneous completion:** ch0–ch3 driven with identical 3,0,3,0 → all four done_pulse bits rise on the same cycle, all_done=1, transfer_count=4.
- **Watchdog:** timeout_cycles=8, ch1 held at 3 after the first marker → timeout[1]=1 after 8 SEEK cycles and transfer_done[1] stays 0. Then enable[1] for 1 cycle → timeout[1]=0 and idx=0.
- **Mid-sequence disturbances:** pulse enable[2] at idx=2 → the sequence restarts and needs 4 fresh markers. Pulse rst at idx=3 → all outputs 0 next cycle, transfer_count=0.
- **Counter saturation:** count_width=2 with 5 completions (re-arm via enable between them) → transfer_count reads 1,2,3,3,3.
- **Tie-break:** timeout_cycles=4 with the final marker arriving on the expiry cycle → transfer_done=1 and timeout=0.

Source files
------------

// File: rtl/mem_copy_monitor_pkg.sv
// Shared types and helpers for the multi-channel memory-copy completion monitor.
//   chan_state_t    : per-channel FSM state (SEEK / DONE / TOUT)
//   idx_width()     : marker-index register width for a given marker count
//   wdog_width()    : watchdog counter width for a given timeout limit
//   expected_marker : marker value expected at a given index for a given lane width
//   IDX_W / WDOG_W  : widths for the default configuration (4 markers, 1024 cycles);
//                     modules derive their own widths from their parameters.
package mem_copy_monitor_pkg;

  typedef enum logic [1:0] {
    SEEK = 2'd0,
    DONE = 2'd1,
    TOUT = 2'd2
  } chan_state_t;

  // Lanes wider than this are not supported by expected_marker.
  localparam int unsigned MAX_MEM_BITS = 64;

  function automatic int idx_width(input int markers);
    int w;
    w = $clog2(markers);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int wdog_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int IDX_W  = idx_width(4);
  localparam int WDOG_W = wdog_width(1024);

  // Even indices expect all-ones, odd indices expect all-zeros.
  function automatic logic [MAX_MEM_BITS-1:0] expected_marker(input int unsigned idx,
                                                             input int unsigned width);
    logic [MAX_MEM_BITS-1:0] ones;
    ones = '0;
    for (int unsigned b = 0; b < MAX_MEM_BITS; b++) begin
      if (b < width) ones[b] = 1'b1;
    end
    return idx[0] ? '0 : ones;
  endfunction

endpackage

// File: rtl/mem_copy_channel_fsm.sv
// One lane of the memory-copy monitor: tracks the alternating marker sequence,
// runs the watchdog and holds the lane's three status flags.
//   clk, rst       : clock, synchronous active-high reset
//   enable         : re-arm/hold at marker index 0 while high
//   lane           : this channel's slice of the memory output
//   transfer_done  : sticky completion flag (registered)
//   done_pulse     : one-cycle pulse when transfer_done rises (registered)
//   timeout        : sticky watchdog-expired flag (registered)
//   done_next      : next-state value of transfer_done (for the top's all_done)
//   pulse_next     : next-state value of done_pulse (for the top's counter)
module mem_copy_channel_fsm
  import mem_copy_monitor_pkg::*;
#(
  parameter int no_of_mem_bits = 2,
  parameter int no_of_markers  = 4,
  parameter int timeout_cycles = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [no_of_mem_bits-1:0] lane,
  output logic                      transfer_done,
  output logic                      done_pulse,
  output logic                      timeout,
  output logic                      done_next,
  output logic                      pulse_next
);

  localparam int IW = idx_width(no_of_markers);
  localparam int WW = wdog_width(timeout_cycles);
  localparam logic [IW-1:0] LAST_IDX  = IW'(no_of_markers - 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'((timeout_cycles > 0) ? timeout_cycles - 1 : 0);
  localparam bit            WDOG_ON   = (timeout_cycles != 0);

  chan_state_t       state, state_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [WW-1:0]     wdog, wdog_nxt;
  logic              hit;
  logic              tout_nxt;

  assign hit = (lane == no_of_mem_bits'(expected_marker(int'(idx), no_of_mem_bits)));

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wdog_nxt  = wdog;
    if (rst || enable) begin
      state_nxt = SEEK;
      idx_nxt   = '0;
      wdog_nxt  = '0;
    end else begin
      unique case (state)
        SEEK: begin
          // Completion is tested before expiry so a final marker on the
          // expiry cycle still counts as done.
          if (hit && idx == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            if (hit) idx_nxt = idx + 1'b1;
            if (WDOG_ON) begin
              if (wdog == WDOG_LAST) state_nxt = TOUT;
              else                   wdog_nxt  = wdog + 1'b1;
            end
          end
        end
        DONE:    state_nxt = DONE;
        TOUT:    state_nxt = TOUT;
        default: begin
          state_nxt = SEEK;
          idx_nxt   = '0;
          wdog_nxt  = '0;
        end
      endcase
    end
    done_next  = (state_nxt == DONE);
    tout_nxt   = (state_nxt == TOUT);
    pulse_next = (state == SEEK) && (state_nxt == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= SEEK;
      idx           <= '0;
      wdog          <= '0;
      transfer_done <= 1'b0;
      done_pulse    <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      wdog          <= wdog_nxt;
      transfer_done <= done_next;
      done_pulse    <= pulse_next;
      timeout       <= tout_nxt;
    end
  end

endmodule

// File: rtl/mem_copy_monitor.sv
// Multi-channel memory-copy completion monitor. Each channel watches its lane
// of the memory output for the alternating all-ones/all-zeros marker sequence.
//   clk, rst       : clock, synchronous active-high reset
//   enable         : per-channel re-arm/hold
//   data_in        : channel c occupies [c*no_of_mem_bits +: no_of_mem_bits]
//   transfer_done  : sticky per-channel done
//   done_pulse     : per-channel one-cycle done pulse
//   timeout        : sticky per-channel watchdog flag
//   all_done       : AND of transfer_done
//   transfer_count : saturating count of done pulses since rst
module mem_copy_monitor
  import mem_copy_monitor_pkg::*;
#(
  parameter int no_of_mem_bits = 2,
  parameter int no_of_channels = 4,
  parameter int no_of_markers  = 4,
  parameter int timeout_cycles = 1024,
  parameter int count_width    = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [no_of_channels-1:0]                enable,
  input  logic [no_of_channels*no_of_mem_bits-1:0] data_in,
  output logic [no_of_channels-1:0]                transfer_done,
  output logic [no_of_channels-1:0]                done_pulse,
  output logic [no_of_channels-1:0]                timeout,
  output logic                                     all_done,
  output logic [count_width-1:0]                   transfer_count
);

  localparam int POP_W = $clog2(no_of_channels + 1);
  localparam int SUM_W = ((count_width > POP_W) ? count_width : POP_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({count_width{1'b1}});

  logic [no_of_channels-1:0] done_next;
  logic [no_of_channels-1:0] pulse_next;
  logic [POP_W-1:0]          pop;
  logic [SUM_W-1:0]          sum;
  logic [count_width-1:0]    count_nxt;

  for (genvar c = 0; c < no_of_channels; c++) begin : g_chan
    mem_copy_channel_fsm #(
      .no_of_mem_bits (no_of_mem_bits),
      .no_of_markers  (no_of_markers),
      .timeout_cycles (timeout_cycles)
    ) u_fsm (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable[c]),
      .lane          (data_in[c*no_of_mem_bits +: no_of_mem_bits]),
      .transfer_done (transfer_done[c]),
      .done_pulse    (done_pulse[c]),
      .timeout       (timeout[c]),
      .done_next     (done_next[c]),
      .pulse_next    (pulse_next[c])
    );
  end

  // Counting next-state pulses keeps the counter in step with done_pulse and
  // credits simultaneous completions individually.
  always_comb begin
    pop = '0;
    for (int unsigned c = 0; c < no_of_channels; c++) begin
      pop = pop + POP_W'(pulse_next[c]);
    end
    sum       = SUM_W'(transfer_count) + SUM_W'(pop);
    count_nxt = (sum > CNT_MAX) ? count_width'(CNT_MAX) : count_width'(sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      all_done       <= 1'b0;
      transfer_count <= '0;
    end else begin
      all_done       <= &done_next;
      transfer_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_mem_copy_monitor.sv
module tb_mem_copy_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] enable;
  logic [7:0] data_in;

  logic [3:0] done_a, pulse_a, tout_a;
  logic       all_a;
  logic [7:0] cnt_a;
  logic [3:0] done_b, pulse_b, tout_b;
  logic       all_b;
  logic [1:0] cnt_b;

  int checks = 0;
  int errors = 0;
  bit checking_on = 1'b0;

  always #5 clk = ~clk;

  mem_copy_monitor #(
    .no_of_mem_bits(2), .no_of_channels(4), .no_of_markers(4),
    .timeout_cycles(8), .count_width(8)
  ) dut_main (
    .clk(clk), .rst(rst), .enable(enable), .data_in(data_in),
    .transfer_done(done_a), .done_pulse(pulse_a), .timeout(tout_a),
    .all_done(all_a), .transfer_count(cnt_a)
  );

  mem_copy_monitor #(
    .no_of_mem_bits(2), .no_of_channels(4), .no_of_markers(4),
    .timeout_cycles(4), .count_width(2)
  ) dut_sat (
    .clk(clk), .rst(rst), .enable(enable), .data_in(data_in),
    .transfer_done(done_b), .done_pulse(pulse_b), .timeout(tout_b),
    .all_done(all_b), .transfer_count(cnt_b)
  );

  // Reference model: per-channel marker position, watchdog age and flags.
  int to_lim [2] = '{8, 4};
  int cnt_max[2] = '{255, 3};
  int m_idx  [2][4];
  int m_age  [2][4];
  bit m_done [2][4];
  bit m_pulse[2][4];
  bit m_tout [2][4];
  int m_cnt  [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      for (int c = 0; c < 4; c++) begin
        m_idx[i][c] = 0; m_age[i][c] = 0;
        m_done[i][c] = 0; m_pulse[i][c] = 0; m_tout[i][c] = 0;
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int added;
      added = 0;
      for (int c = 0; c < 4; c++) begin
        int lane;
        int want;
        lane = int'(data_in[2*c +: 2]);
        want = (m_idx[i][c] % 2 == 0) ? 3 : 0;
        m_pulse[i][c] = 0;
        if (rst || enable[c]) begin
          m_idx[i][c] = 0; m_age[i][c] = 0;
          m_done[i][c] = 0; m_tout[i][c] = 0;
        end else if (!m_done[i][c] && !m_tout[i][c]) begin
          if (lane == want && m_idx[i][c] == 3) begin
            m_done[i][c] = 1; m_pulse[i][c] = 1;
          end else begin
            if (lane == want) m_idx[i][c] = m_idx[i][c] + 1;
            m_age[i][c] = m_age[i][c] + 1;
            if (to_lim[i] != 0 && m_age[i][c] >= to_lim[i]) m_tout[i][c] = 1;
          end
        end
        added = added + int'(m_pulse[i][c]);
      end
      if (rst) m_cnt[i] = 0;
      else     m_cnt[i] = (m_cnt[i] + added > cnt_max[i]) ? cnt_max[i] : m_cnt[i] + added;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checking_on) begin
      for (int i = 0; i < 2; i++) begin
        logic [3:0] ed, ep, et;
        logic [3:0] ad, ap, at;
        logic       aa;
        int         ac;
        for (int c = 0; c < 4; c++) begin
          ed[c] = m_done[i][c]; ep[c] = m_pulse[i][c]; et[c] = m_tout[i][c];
        end
        if (i == 0) begin
          ad = done_a; ap = pulse_a; at = tout_a; aa = all_a; ac = int'(cnt_a);
        end else begin
          ad = done_b; ap = pulse_b; at = tout_b; aa = all_b; ac = int'(cnt_b);
        end
        chk($sformatf("model inst%0d transfer_done", i), int'(ad), int'(ed));
        chk($sformatf("model inst%0d done_pulse", i), int'(ap), int'(ep));
        chk($sformatf("model inst%0d timeout", i), int'(at), int'(et));
        chk($sformatf("model inst%0d all_done", i), int'(aa), int'(&ed));
        chk($sformatf("model inst%0d transfer_count", i), ac, m_cnt[i]);
      end
    end
  end

  function automatic logic [7:0] pack(input logic [1:0] l0, input logic [1:0] l1,
                                      input logic [1:0] l2, input logic [1:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic cyc(input logic r, input logic [3:0] e, input logic [7:0] d);
    rst = r; enable = e; data_in = d;
    @(negedge clk);
  endtask

  int basic_seq[7] = '{3, 1, 0, 2, 3, 3, 0};
  int exp_sat[5]   = '{1, 2, 3, 3, 3};

  initial begin
    rst = 1'b1; enable = '0; data_in = '0;
    cyc(1, 4'h0, 8'h00);
    checking_on = 1'b1;
    cyc(1, 4'h0, 8'h00);
    chk("reset count", int'(cnt_a), 0);
    chk("reset done", int'(done_a), 0);
    chk("reset timeout", int'(tout_a), 0);

    // Basic completion on channel 0
    for (int k = 0; k < 7; k++) begin
      cyc(0, 4'h0, pack(2'(basic_seq[k]), 2'd0, 2'd0, 2'd0));
      if (k == 5) chk("basic not yet done", int'(done_a[0]), 0);
    end
    chk("basic done", int'(done_a[0]), 1);
    chk("basic pulse", int'(pulse_a), 1);
    chk("basic count", int'(cnt_a), 1);
    chk("basic sat ch0 timeout", int'(tout_b[0]), 1);
    cyc(0, 4'h0, 8'h00);
    chk("basic pulse drops", int'(pulse_a), 0);
    chk("basic done sticky", int'(done_a[0]), 1);
    chk("basic count hold", int'(cnt_a), 1);

    // Simultaneous completion; on dut_sat the last marker lands on expiry
    cyc(1, 4'h0, 8'h00);
    cyc(0, 4'h0, 8'hFF);
    cyc(0, 4'h0, 8'h00);
    cyc(0, 4'h0, 8'hFF);
    cyc(0, 4'h0, 8'h00);
    chk("simul pulse", int'(pulse_a), 15);
    chk("simul all_done", int'(all_a), 1);
    chk("simul count", int'(cnt_a), 4);
    chk("tiebreak done", int'(done_b), 15);
    chk("tiebreak timeout", int'(tout_b), 0);
    chk("simul sat count", int'(cnt_b), 3);
    cyc(0, 4'h0, 8'hFF);
    chk("simul pulse drops", int'(pulse_a), 0);

    // Watchdog on channel 1
    cyc(1, 4'b1101, 8'h00);
    for (int n = 1; n <= 8; n++) begin
      cyc(0, 4'b1101, pack(2'd0, 2'd3, 2'd0, 2'd0));
      if (n == 4) chk("wdog sat expiry", int'(tout_b[1]), 1);
      if (n == 7) chk("wdog before expiry", int'(tout_a[1]), 0);
    end
    chk("wdog expiry", int'(tout_a[1]), 1);
    chk("wdog no done", int'(done_a[1]), 0);
    cyc(0, 4'b1111, 8'h00);
    chk("wdog re-arm", int'(tout_a[1]), 0);
    cyc(0, 4'b1101, pack(2'd0, 2'd3, 2'd0, 2'd0));
    cyc(0, 4'b1101, pack(2'd0, 2'd0, 2'd0, 2'd0));
    cyc(0, 4'b1101, pack(2'd0, 2'd3, 2'd0, 2'd0));
    cyc(0, 4'b1101, pack(2'd0, 2'd0, 2'd0, 2'd0));
    chk("wdog fresh sequence", int'(done_a[1]), 1);

    // Enable pulse mid-sequence on channel 2
    cyc(1, 4'h0, 8'h00);
    cyc(0, 4'b1011, pack(2'd0, 2'd0, 2'd3, 2'd0));
    cyc(0, 4'b1011, pack(2'd0, 2'd0, 2'd0, 2'd0));
    cyc(0, 4'b1111, pack(2'd0, 2'd0, 2'd3, 2'd0));
    cyc(0, 4'b1011, pack(2'd0, 2'd0, 2'd3, 2'd0));
    cyc(0, 4'b1011, pack(2'd0, 2'd0, 2'd0, 2'd0));
    cyc(0, 4'b1011, pack(2'd0, 2'd0, 2'd3, 2'd0));
    chk("restart needs 4", int'(done_a[2]), 0);
    cyc(0, 4'b1011, pack(2'd0, 2'd0, 2'd0, 2'd0));
    chk("restart done", int'(done_a[2]), 1);
    chk("restart count", int'(cnt_a), 1);

    // Reset mid-sequence on channel 3
    cyc(0, 4'b0111, pack(2'd0, 2'd0, 2'd0, 2'd3));
    cyc(0, 4'b0111, pack(2'd0, 2'd0, 2'd0, 2'd0));
    cyc(0, 4'b0111, pack(2'd0, 2'd0, 2'd0, 2'd3));
    cyc(1, 4'b0111, pack(2'd0, 2'd0, 2'd0, 2'd0));
    chk("mid rst count", int'(cnt_a), 0);
    chk("mid rst done", int'(done_a), 0);
    chk("mid rst pulse", int'(pulse_a), 0);
    chk("mid rst all_done", int'(all_a), 0);

    // Counter saturation with re-arm between completions
    cyc(1, 4'h0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 4'b1110, pack(2'd3, 2'd0, 2'd0, 2'd0));
      cyc(0, 4'b1110, pack(2'd0, 2'd0, 2'd0, 2'd0));
      cyc(0, 4'b1110, pack(2'd3, 2'd0, 2'd0, 2'd0));
      cyc(0, 4'b1110, pack(2'd0, 2'd0, 2'd0, 2'd0));
      chk($sformatf("sat count %0d", k), int'(cnt_b), exp_sat[k]);
      chk($sformatf("wide count %0d", k), int'(cnt_a), k + 1);
      cyc(0, 4'b1111, 8'h00);
    end

    checking_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
